// File: rtl/tbus_arbiter_2req.sv
// Two-requester round-robin arbiter for a shared tristate bus, with bounded bursts
// and a one-cycle dead gap between owners so the bus drivers never overlap.
module tbus_arbiter_2req #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic          sel,
    output logic          bus_en,
    output logic          gap,
    output logic [CW-1:0] burst_cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    state_t        w_pick;
    logic          r_last_owner;
    logic          r_sel;
    logic [CW-1:0] r_burst_cnt;
    logic          w_enter_own;
    logic          w_stay_own;

    // Arbitration from IDLE or GAP; ties go to whoever did not own the bus last.
    always_comb begin
        w_pick = S_IDLE;
        case (req)
            2'b01:   w_pick = S_OWN0;
            2'b10:   w_pick = S_OWN1;
            2'b11:   w_pick = r_last_owner ? S_OWN0 : S_OWN1;
            default: w_pick = S_IDLE;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = w_pick;
            S_OWN0: begin
                if (!req[0] || (r_burst_cnt == CNT_MAX && req[1]))
                    w_next = S_GAP;
            end
            S_OWN1: begin
                if (!req[1] || (r_burst_cnt == CNT_MAX && req[0]))
                    w_next = S_GAP;
            end
            S_GAP:   w_next = w_pick;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_own = ((r_state == S_IDLE) || (r_state == S_GAP)) &&
                         ((w_next == S_OWN0) || (w_next == S_OWN1));
    assign w_stay_own  = ((r_state == S_OWN0) || (r_state == S_OWN1)) && (w_next == r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_sel        <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_next;

            // sel only moves when a new owner is granted, never while driving.
            if (w_enter_own)
                r_sel <= (w_next == S_OWN1);

            if (w_stay_own && r_burst_cnt != CNT_MAX)
                r_burst_cnt <= r_burst_cnt + CW'(1);
            else if (!w_stay_own)
                r_burst_cnt <= '0;

            if (r_state == S_OWN0 && w_next == S_GAP)
                r_last_owner <= 1'b0;
            else if (r_state == S_OWN1 && w_next == S_GAP)
                r_last_owner <= 1'b1;
        end
    end

    always_comb begin
        gnt    = 2'b00;
        bus_en = 1'b0;
        gap    = 1'b0;
        case (r_state)
            S_OWN0: begin
                gnt    = 2'b01;
                bus_en = 1'b1;
            end
            S_OWN1: begin
                gnt    = 2'b10;
                bus_en = 1'b1;
            end
            S_GAP:   gap = 1'b1;
            default: gnt = 2'b00;
        endcase
    end

    assign sel       = r_sel;
    assign burst_cnt = r_burst_cnt;

endmodule
